mem_loader: RTL

Boot-time loader that fills the instruction or data memory from a byte stream before the CPU runs. It is the write side of the word memories: it accepts bytes over a valid/ready handshake, packs four bytes into a 32-bit word, and issues single-cycle write strobes with a word-aligned byte address. While the load runs, the core is held off via `Busy`. On completion it raises `Done`, and `Error` reports any checksum failure.

---
 rtl/mem_loader_pkg.sv | 17 +
 rtl/mem_loader_if.sv | 31 +++
 rtl/mem_loader_byte_packer.sv | 44 ++++
 rtl/mem_loader.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot-time memory loader.
// Optional checksum support is enabled with MEM_LOADER_CHECKSUM_EN.
package mem_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;
    localparam int WORD_W     = WORD_BYTES * BYTE_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream input and word-memory write bus of the loader.
// Unaffected by MEM_LOADER_CHECKSUM_EN.
interface mem_loader_if;
    import mem_loader_pkg::*;

    logic [BYTE_W-1:0] ByteIn;
    logic              ByteValid;
    logic              ByteReady;
    logic [31:0]       MemAddress;
    logic [WORD_W-1:0] MemWriteData;
    logic              MemWrite;

    modport master (
        input  ByteIn,
        input  ByteValid,
        output ByteReady,
        output MemAddress,
        output MemWriteData,
        output MemWrite
    );

    modport slave (
        output ByteIn,
        output ByteValid,
        input  ByteReady,
        input  MemAddress,
        input  MemWriteData,
        input  MemWrite
    );

endinterface

// File: rtl/mem_loader_byte_packer.sv
// Little-endian byte-to-word assembler with a 4th-byte pulse.
// Unaffected by MEM_LOADER_CHECKSUM_EN.
module byte_packer
    import mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_ready
);

    logic [1:0]               cnt_q, cnt_d;
    logic [WORD_W-BYTE_W-1:0] shift_q, shift_d;

    // Bytes enter at the top so the first one ends up in [7:0].
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clr) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_en) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {byte_in, shift_q[WORD_W-BYTE_W-1:BYTE_W]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign word       = {byte_in, shift_q};
    assign word_ready = byte_en && !clr && (cnt_q == 2'd3);

endmodule

// File: rtl/mem_loader.sv
// Boot loader: packs a byte stream into words and writes them to memory.
// Define MEM_LOADER_CHECKSUM_EN to append an XOR checksum byte check.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Start,
    input  logic [ADDR_W:0] WordCount,
    mem_loader_if.master  bus,
    output logic          Busy,
    output logic          Done,
    output logic          Error
);

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

`ifdef MEM_LOADER_CHECKSUM_EN
    localparam loader_state_t LAST_ST = ST_CHECK;
    logic [BYTE_W-1:0] xor_q, xor_d;
    logic              err_q, err_d;
`else
    localparam loader_state_t LAST_ST = ST_DONE;
`endif

    loader_state_t     state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   idx_nxt, req_words;
    logic [31:0]       addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              start_ok, byte_en;
    logic              word_ready;
    logic [WORD_W-1:0] word;

    assign start_ok  = Start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign byte_en   = bus.ByteValid && bus.ByteReady;
    assign req_words = (WordCount > MAX_WORDS) ? MAX_WORDS : WordCount;
    assign idx_nxt   = idx_q + (ADDR_W+1)'(1);

    byte_packer u_packer (
        .clk        (Clk),
        .rst_n      (Rst_n),
        .clr        (start_ok),
        .byte_en    (byte_en && state_q == ST_RECV),
        .byte_in    (bus.ByteIn),
        .word       (word),
        .word_ready (word_ready)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    idx_d   = '0;
                    cnt_d   = req_words;
                    state_d = (req_words == '0) ? LAST_ST : ST_RECV;
`ifdef MEM_LOADER_CHECKSUM_EN
                    xor_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            ST_RECV: begin
`ifdef MEM_LOADER_CHECKSUM_EN
                if (byte_en) xor_d = xor_q ^ bus.ByteIn;
`endif
                if (word_ready) begin
                    state_d = ST_WRITE;
                    wr_d    = 1'b1;
                    wdata_d = word;
                    addr_d  = 32'({idx_q, 2'b00});
                end
            end
            ST_WRITE: begin
                idx_d   = idx_nxt;
                state_d = (idx_nxt < cnt_q) ? ST_RECV : LAST_ST;
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (byte_en) begin
                    err_d   = (bus.ByteIn != xor_q);
                    state_d = ST_DONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
            xor_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
`ifdef MEM_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.ByteReady    = (state_q == ST_RECV) || (state_q == ST_CHECK);
    assign bus.MemAddress   = addr_q;
    assign bus.MemWriteData = wdata_q;
    assign bus.MemWrite     = wr_q;
    assign Busy = (state_q == ST_RECV) || (state_q == ST_WRITE) ||
                  (state_q == ST_CHECK);
    assign Done = (state_q == ST_DONE);
`ifdef MEM_LOADER_CHECKSUM_EN
    assign Error = err_q;
`else
    assign Error = 1'b0;
`endif

endmodule
